// File: rtl/coin_change_dispenser.sv
// ============================================================================
// Module   : coin_change_dispenser
// Purpose  : Pays a refund credit back out as greedy coin codes over valid/ready.
//            Define COIN_DISPENSE_PENTAGON_EN to enable pentagon (5) coins.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module coin_change_dispenser (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] credit,
    input  logic       refund,
    input  logic       ready,
    output logic [1:0] coin,
    output logic       valid,
    output logic       busy,
    output logic       done,
    output logic [3:0] coin_count
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPENSE = 2'd1,
        S_DONE     = 2'd2
    } state_t;

    localparam logic [1:0] c_COIN_NONE     = 2'b00;
    localparam logic [1:0] c_COIN_CIRCLE   = 2'b01;
    localparam logic [1:0] c_COIN_TRIANGLE = 2'b10;
    localparam logic [1:0] c_COIN_PENTAGON = 2'b11;

    state_t     r_state;
    logic [3:0] r_remaining;
    logic [3:0] r_coin_count;
    logic       r_valid;
    logic       r_busy;
    logic       r_done;

    logic [1:0] w_coin_sel;
    logic [3:0] w_coin_value;
    logic [3:0] w_remaining_next;

    // Greedy pick never exceeds r_remaining, so the subtraction cannot wrap.
    always_comb begin
        w_coin_sel   = c_COIN_CIRCLE;
        w_coin_value = 4'd1;
`ifdef COIN_DISPENSE_PENTAGON_EN
        if (r_remaining >= 4'd5) begin
            w_coin_sel   = c_COIN_PENTAGON;
            w_coin_value = 4'd5;
        end else if (r_remaining >= 4'd3) begin
            w_coin_sel   = c_COIN_TRIANGLE;
            w_coin_value = 4'd3;
        end
`else
        if (r_remaining >= 4'd3) begin
            w_coin_sel   = c_COIN_TRIANGLE;
            w_coin_value = 4'd3;
        end
`endif
        w_remaining_next = r_remaining - w_coin_value;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_remaining  <= 4'd0;
            r_coin_count <= 4'd0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (refund) begin
                        r_coin_count <= 4'd0;
                        r_busy       <= 1'b1;
                        if (credit != 4'd0) begin
                            r_remaining <= credit;
                            r_valid     <= 1'b1;
                            r_state     <= S_DISPENSE;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DISPENSE: begin
                    if (ready) begin
                        r_remaining  <= w_remaining_next;
                        r_coin_count <= r_coin_count + 4'd1;
                        if (w_remaining_next == 4'd0) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign coin       = r_valid ? w_coin_sel : c_COIN_NONE;
    assign valid      = r_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign coin_count = r_coin_count;

endmodule

`default_nettype wire

// File: tb/tb_coin_change_dispenser.sv
// Testbench for coin_change_dispenser: queue-based reference model plus directed literal checks.
`default_nettype none

module tb_coin_change_dispenser;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] credit;
    logic       refund;
    logic       ready;
    logic [1:0] coin;
    logic       valid;
    logic       busy;
    logic       done;
    logic [3:0] coin_count;

    coin_change_dispenser dut (
        .clock      (clock),
        .reset      (reset),
        .credit     (credit),
        .refund     (refund),
        .ready      (ready),
        .coin       (coin),
        .valid      (valid),
        .busy       (busy),
        .done       (done),
        .coin_count (coin_count)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 paying out, 2 done pulse; q holds the coins still owed.
    int m_phase = 0;
    int m_count = 0;
    int q[$];

    function automatic void greedy(input int c);
        q.delete();
        while (c > 0) begin
`ifdef COIN_DISPENSE_PENTAGON_EN
            if (c >= 5) begin q.push_back(3); c -= 5; end
            else
`endif
            if (c >= 3) begin q.push_back(2); c -= 3; end
            else begin q.push_back(1); c -= 1; end
        end
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_phase = 0;
            m_count = 0;
            q.delete();
        end else begin
            case (m_phase)
                0: if (refund) begin
                    m_count = 0;
                    greedy(int'(credit));
                    m_phase = (q.size() != 0) ? 1 : 2;
                end
                1: if (ready) begin
                    void'(q.pop_front());
                    m_count++;
                    if (q.size() == 0) m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("model_valid", valid, (m_phase == 1) ? 1 : 0);
            chk("model_coin", coin, (m_phase == 1) ? q[0] : 0);
            chk("model_busy", busy, (m_phase != 0) ? 1 : 0);
            chk("model_done", done, (m_phase == 2) ? 1 : 0);
            chk("model_coin_count", coin_count, m_count);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({nm, "_done_seen"}, done, 1);
    endtask

    initial begin
        int exp13[$];
        int exp15_n;
`ifdef COIN_DISPENSE_PENTAGON_EN
        exp13   = '{3, 3, 2};
        exp15_n = 3;
`else
        exp13   = '{2, 2, 2, 2, 1};
        exp15_n = 5;
`endif
        reset  = 1'b1;
        refund = 1'b0;
        credit = 4'd0;
        ready  = 1'b0;
        step();
        chk_en = 1'b1;
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_coin", coin, 0);
        chk("rst_coin_count", coin_count, 0);
        reset = 1'b0;
        step();

        // Credit 13, ready held high.
        credit = 4'd13; refund = 1'b1; ready = 1'b1;
        step();
        refund = 1'b0;
        for (int i = 0; i < exp13.size(); i++) begin
            chk("c13_valid", valid, 1);
            chk("c13_coin", coin, exp13[i]);
            step();
        end
        chk("c13_done", done, 1);
        chk("c13_valid_low", valid, 0);
        chk("c13_count", coin_count, exp13.size());
        step();
        chk("c13_idle_busy", busy, 0);
        chk("c13_count_hold", coin_count, exp13.size());

        // Credit 7 with ready pattern 1,0,0,1,1.
        credit = 4'd7; refund = 1'b1; ready = 1'b1;
        step();
        refund = 1'b0;
        begin
            logic [1:0] held;
            step();
            held = coin;
            ready = 1'b0;
            step();
            chk("c7_hold1", coin, held);
            step();
            chk("c7_hold2", coin, held);
            ready = 1'b1;
`ifdef COIN_DISPENSE_PENTAGON_EN
            chk("c7_held_code", held, 1);
`else
            chk("c7_held_code", held, 2);
`endif
        end
        step();
        step();
        chk("c7_done", done, 1);
        chk("c7_count", coin_count, 3);
        step();

        // Credit 0 request.
        credit = 4'd0; refund = 1'b1;
        step();
        refund = 1'b0;
        chk("c0_done", done, 1);
        chk("c0_valid", valid, 0);
        chk("c0_count", coin_count, 0);
        step();
        chk("c0_idle_done", done, 0);
        chk("c0_idle_busy", busy, 0);

        // Reset mid-refund after one coin.
        credit = 4'd13; refund = 1'b1; ready = 1'b1;
        step();
        refund = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_count", coin_count, 0);
        chk("mid_rst_done", done, 0);
        reset = 1'b0;
        step();
        chk("mid_rst_no_done", done, 0);

        // Credit 15 with refund held high the whole time.
        credit = 4'd15; refund = 1'b1; ready = 1'b1;
        step();
        wait_done("c15");
        chk("c15_count", coin_count, exp15_n);
        step();
        chk("c15_idle_busy", busy, 0);
        chk("c15_idle_valid", valid, 0);
        step();
        chk("c15_restart_valid", valid, 1);
        refund = 1'b0;
        wait_done("c15b");
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            reset  = ($urandom_range(0, 79) == 0);
            refund = ($urandom_range(0, 3) == 0);
            credit = 4'($urandom_range(0, 15));
            ready  = ($urandom_range(0, 2) != 0);
            step();
        end
        reset = 1'b0; refund = 1'b0; ready = 1'b1;
        repeat (25) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
